// File: rtl/adat_o_feeder.sv
// ADAT output feeder: reads one frame of samples from the sample RAM per frame_start and streams them as addr/data/valid.
// Optional TPDF dither on the output words is compiled in with `define ADAT_O_FEED_DITHER_EN.
module adat_o_feeder #(
  parameter int          ADAT_OUTPUTS = 1,
  parameter logic [7:0]  RAM_BASE     = 8'h00
) (
  input  logic        master_bclk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        ram_rd_en,
  output logic [7:0]  ram_rd_addr,
  input  logic [31:0] ram_q,
  output logic [7:0]  addr,
  output logic [31:0] data,
  output logic        valid,
  output logic        frame_done,
  output logic        overrun
);

  localparam int         N    = 8 * ADAT_OUTPUTS;
  localparam logic [7:0] LAST = 8'(N - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic        rd_en_q, rd_en_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        drain_q, drain_d;
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;
  logic        rd_en_p_q, rd_en_p_d;
  logic [7:0]  rd_cnt_p_q, rd_cnt_p_d;
  logic        valid_q, valid_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] word;

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    unique case (state_q)
      IDLE, DONE: begin
        // A frame_start coinciding with frame_done starts the next frame at once.
        if (frame_start) begin
          state_d   = READ;
          rd_cnt_d  = 8'd0;
          rd_en_d   = 1'b1;
          rd_addr_d = RAM_BASE;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (frame_start) overrun_d = 1'b1;
        if (rd_cnt_q == LAST) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          rd_cnt_d  = rd_cnt_q + 8'd1;
          rd_en_d   = 1'b1;
          rd_addr_d = RAM_BASE + rd_cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        if (frame_start) overrun_d = 1'b1;
        if (drain_q) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // ram_q lines up with the read issued one cycle earlier, hence the delayed index.
    rd_en_p_d  = rd_en_q;
    rd_cnt_p_d = rd_cnt_q;
    valid_d    = rd_en_p_q;
    addr_d     = rd_en_p_q ? rd_cnt_p_q : addr_q;
    data_d     = rd_en_p_q ? word : data_q;
  end

`ifdef ADAT_O_FEED_DITHER_EN
  logic [31:0] lfsr1_q, lfsr1_d, lfsr2_q, lfsr2_d;
  logic [9:0]  noise;
  logic [32:0] sum;
  logic [31:0] sat;

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
  endfunction

  always_comb begin
    noise = {2'b00, lfsr1_q[7:0]} + {2'b00, lfsr2_q[7:0]} - 10'd255;
    sum   = {ram_q[31], ram_q} + {{23{noise[9]}}, noise};
    if (sum[32] != sum[31]) sat = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else                    sat = sum[31:0];
    word    = sat & 32'hFFFF_FF00;
    lfsr1_d = rd_en_p_q ? lfsr_step(lfsr1_q) : lfsr1_q;
    lfsr2_d = rd_en_p_q ? lfsr_step(lfsr2_q) : lfsr2_q;
  end

  always_ff @(posedge master_bclk) begin
    if (reset) begin
      lfsr1_q <= 32'h0000_0001;
      lfsr2_q <= 32'hACE1_2468;
    end else begin
      lfsr1_q <= lfsr1_d;
      lfsr2_q <= lfsr2_d;
    end
  end
`else
  assign word = ram_q;
`endif

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge master_bclk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_cnt_q     <= 8'd0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 8'd0;
      drain_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_en_p_q    <= 1'b0;
      rd_cnt_p_q   <= 8'd0;
      valid_q      <= 1'b0;
      addr_q       <= 8'd0;
      data_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      drain_q      <= drain_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      rd_en_p_q    <= rd_en_p_d;
      rd_cnt_p_q   <= rd_cnt_p_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = rd_addr_q;
  assign addr        = addr_q;
  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adat_o_feeder.sv
// Bench for adat_o_feeder: three instances (N=8 base 00, N=8 base FC, N=64 base 40) checked cycle by cycle
// against a frame-timing model driven by the frame_start/reset schedule.
module tb_adat_o_feeder;

  localparam int         W_MAX    = 512;
  localparam int         OUTS [3] = '{1, 1, 8};
  localparam logic [7:0] BASES[3] = '{8'h00, 8'hFC, 8'h40};

  logic master_bclk = 1'b0;
  always #5 master_bclk = ~master_bclk;

  logic [31:0] mem [256];

  logic        rst_w     [3];
  logic        fs_w      [3];
  logic        rd_en_w   [3];
  logic [7:0]  rd_addr_w [3];
  logic [31:0] ram_q_w   [3];
  logic [7:0]  addr_w    [3];
  logic [31:0] data_w    [3];
  logic        valid_w   [3];
  logic        done_w    [3];
  logic        ovr_w     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adat_o_feeder #(.ADAT_OUTPUTS(OUTS[g]), .RAM_BASE(BASES[g])) dut (
      .master_bclk (master_bclk),
      .reset       (rst_w[g]),
      .frame_start (fs_w[g]),
      .ram_rd_en   (rd_en_w[g]),
      .ram_rd_addr (rd_addr_w[g]),
      .ram_q       (ram_q_w[g]),
      .addr        (addr_w[g]),
      .data        (data_w[g]),
      .valid       (valid_w[g]),
      .frame_done  (done_w[g]),
      .overrun     (ovr_w[g])
    );
    always @(posedge master_bclk) if (rd_en_w[g]) ram_q_w[g] <= mem[rd_addr_w[g]];
  end

  int checks = 0;
  int failures = 0;

  int starts_q[$];
  int resets_q[$];
  bit          e_rd_en [W_MAX];
  bit          e_valid [W_MAX];
  bit          e_done  [W_MAX];
  bit          e_ovr   [W_MAX];
  logic [7:0]  e_rd_addr [W_MAX];
  logic [7:0]  e_addr    [W_MAX];
  logic [31:0] e_data    [W_MAX];

  int          words_seen, done_seen, exp_words;
  logic [7:0]  rd_addr_log[$];
  logic [7:0]  addr_log[$];

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Frame timing derived from the accepted frame_start cycle: offset o = cycle - start.
  task automatic build_model(input int sel, input int len);
    int n, base, act, o;
    bit ovr;
    logic [7:0]  rah, ah;
    logic [31:0] dh;
    n = 8 * OUTS[sel]; base = int'(BASES[sel]);
    act = -1; ovr = 1'b0; rah = 8'd0; ah = 8'd0; dh = 32'd0; exp_words = 0;
    for (int c = 0; c < len; c++) begin
      e_rd_en[c] = 1'b0; e_valid[c] = 1'b0; e_done[c] = 1'b0;
      if (act >= 0) begin
        o = c - act;
        if (o >= 1 && o <= n) begin e_rd_en[c] = 1'b1; rah = 8'((base + o - 1) % 256); end
        if (o >= 3 && o <= n + 2) begin
          e_valid[c] = 1'b1; ah = 8'(o - 3); dh = mem[(base + o - 3) % 256];
          if (c >= 1) exp_words++;
        end
        if (o == n + 3) e_done[c] = 1'b1;
      end
      e_rd_addr[c] = rah; e_addr[c] = ah; e_data[c] = dh; e_ovr[c] = ovr;
      if (in_q(resets_q, c)) begin
        act = -1; ovr = 1'b0; rah = 8'd0; ah = 8'd0; dh = 32'd0;
      end else if (in_q(starts_q, c)) begin
        if (act < 0 || c - act >= n + 3) act = c;
        else ovr = 1'b1;
      end
    end
  endtask

  task automatic run_scenario(input int sel, input int len);
    longint lo, hi, act_d;
    build_model(sel, len);
    words_seen = 0; done_seen = 0;
    rd_addr_log.delete(); addr_log.delete();
    for (int c = 0; c < len; c++) begin
      @(posedge master_bclk); #1;
      rst_w[sel] = in_q(resets_q, c);
      fs_w[sel]  = in_q(starts_q, c);
      @(negedge master_bclk);
      if (c >= 1) begin
        if (rd_en_w[sel]) rd_addr_log.push_back(rd_addr_w[sel]);
        if (valid_w[sel]) begin words_seen++; addr_log.push_back(addr_w[sel]); end
        if (done_w[sel]) done_seen++;
        checks += 6;
        if (rd_en_w[sel] !== e_rd_en[c]) begin failures++;
          $display("FAIL rd_en dut%0d cyc=%0d got=%0b exp=%0b", sel, c, rd_en_w[sel], e_rd_en[c]); end
        if (rd_addr_w[sel] !== e_rd_addr[c]) begin failures++;
          $display("FAIL rd_addr dut%0d cyc=%0d got=%h exp=%h", sel, c, rd_addr_w[sel], e_rd_addr[c]); end
        if (valid_w[sel] !== e_valid[c]) begin failures++;
          $display("FAIL valid dut%0d cyc=%0d got=%0b exp=%0b", sel, c, valid_w[sel], e_valid[c]); end
        if (addr_w[sel] !== e_addr[c]) begin failures++;
          $display("FAIL addr dut%0d cyc=%0d got=%h exp=%h", sel, c, addr_w[sel], e_addr[c]); end
        if (done_w[sel] !== e_done[c]) begin failures++;
          $display("FAIL frame_done dut%0d cyc=%0d got=%0b exp=%0b", sel, c, done_w[sel], e_done[c]); end
        if (ovr_w[sel] !== e_ovr[c]) begin failures++;
          $display("FAIL overrun dut%0d cyc=%0d got=%0b exp=%0b", sel, c, ovr_w[sel], e_ovr[c]); end
`ifdef ADAT_O_FEED_DITHER_EN
        lo    = clamp32(longint'($signed(e_data[c])) - 255) & ~64'sd255;
        hi    = clamp32(longint'($signed(e_data[c])) + 255) & ~64'sd255;
        act_d = longint'($signed(data_w[sel]));
        checks++;
        if ($isunknown(data_w[sel]) || act_d < lo || act_d > hi || data_w[sel][7:0] != 8'h00) begin
          failures++;
          $display("FAIL data_dither dut%0d cyc=%0d got=%h raw=%h", sel, c, data_w[sel], e_data[c]);
        end
`else
        checks++;
        if (data_w[sel] !== e_data[c]) begin failures++;
          $display("FAIL data dut%0d cyc=%0d got=%h exp=%h", sel, c, data_w[sel], e_data[c]); end
`endif
      end
    end
    @(posedge master_bclk); #1;
    rst_w[sel] = 1'b0; fs_w[sel] = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic test_reset_idle();
    fill_random();
    starts_q = {}; resets_q = {0};
    run_scenario(0, 110);
    checks++;
    if (rd_addr_log.size() != 0) begin failures++;
      $display("FAIL idle_rd_en got=%0d reads exp=0", rd_addr_log.size()); end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
    starts_q = {10}; resets_q = {0};
    run_scenario(0, 40);
    checks += 2;
    if (words_seen != 8) begin failures++; $display("FAIL basic_words got=%0d exp=8", words_seen); end
    if (done_seen != 1)  begin failures++; $display("FAIL basic_done got=%0d exp=1", done_seen); end
  endtask

  task automatic test_base_wrap();
    logic [7:0] exp_addrs [8];
    exp_addrs = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    fill_random();
    starts_q = {10}; resets_q = {0};
    run_scenario(1, 40);
    checks++;
    if (rd_addr_log.size() != 8 || addr_log.size() != 8) begin failures++;
      $display("FAIL wrap_len got=%0d/%0d exp=8/8", rd_addr_log.size(), addr_log.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks += 2;
      if (rd_addr_log[i] !== exp_addrs[i]) begin failures++;
        $display("FAIL wrap_rd_addr idx=%0d got=%h exp=%h", i, rd_addr_log[i], exp_addrs[i]); end
      if (addr_log[i] !== 8'(i)) begin failures++;
        $display("FAIL wrap_addr idx=%0d got=%h exp=%h", i, addr_log[i], 8'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    starts_q = {5, 72, 92, 139}; resets_q = {0};
    run_scenario(2, 215);
    checks += 3;
    if (words_seen != 192) begin failures++; $display("FAIL b2b_words got=%0d exp=192", words_seen); end
    if (done_seen != 3)    begin failures++; $display("FAIL b2b_done got=%0d exp=3", done_seen); end
    if (ovr_w[2] !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%0b exp=1", ovr_w[2]); end
  endtask

  task automatic test_mid_reset();
    fill_random();
    starts_q = {10, 40}; resets_q = {0, 15};
    run_scenario(2, 115);
    checks += 2;
    if (words_seen != 67) begin failures++; $display("FAIL midrst_words got=%0d exp=67", words_seen); end
    if (done_seen != 1)   begin failures++; $display("FAIL midrst_done got=%0d exp=1", done_seen); end
  endtask

  task automatic test_random();
    int sel, n, t, len;
    for (int it = 0; it < 8; it++) begin
      fill_random();
      sel = $urandom_range(0, 2);
      n   = 8 * OUTS[sel];
      len = 380;
      starts_q = {}; resets_q = {0};
      t = $urandom_range(2, 10);
      while (t < len - n - 6) begin
        starts_q.push_back(t);
        t += $urandom_range(1, n + 8);
      end
      if ($urandom_range(0, 2) == 0) resets_q.push_back($urandom_range(20, 300));
      run_scenario(sel, len);
      checks++;
      if (words_seen != exp_words) begin failures++;
        $display("FAIL rand_words it=%0d got=%0d exp=%0d", it, words_seen, exp_words); end
    end
  endtask

`ifdef ADAT_O_FEED_DITHER_EN
  task automatic test_dither();
    for (int i = 0; i < 256; i++) mem[i] = 32'h7FFF_FF00;
    starts_q = {5, 72}; resets_q = {0};
    run_scenario(2, 145);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    run_scenario(2, 145);
  endtask
`endif

  initial begin
    for (int i = 0; i < 3; i++) begin rst_w[i] = 1'b1; fs_w[i] = 1'b0; ram_q_w[i] = 32'd0; end
    repeat (3) @(posedge master_bclk);
    #1;
    for (int i = 0; i < 3; i++) rst_w[i] = 1'b0;
    test_reset_idle();
    test_basic_frame();
    test_base_wrap();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef ADAT_O_FEED_DITHER_EN
    test_dither();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
